// File: rtl/dual_priority_decoder.sv
// rtl/dual_priority_decoder.sv - validate a {first, second} index pair and hold its decoded 12-line vector
// Define DUAL_PRIORITY_BLINK_EN to blink the second-priority line with half-period BLINK_HALF.
module dual_priority_decoder #(
  parameter int unsigned HOLD_CYCLES = 12_000_000,
  parameter int unsigned BLINK_HALF  = 3_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [3:0]  first,
  input  logic [3:0]  second,
  output logic [12:1] r,
  output logic        valid,
  output logic        err
);

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  localparam logic [23:0] HOLD_RELOAD = 24'(HOLD_CYCLES - 1);

  // Out-of-range timing parameters are rejected at elaboration.
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 32'h00FF_FFFF) begin : g_bad_hold
    $error("HOLD_CYCLES out of range");
  end
  if (BLINK_HALF < 1 || BLINK_HALF > 32'h00FF_FFFF) begin : g_bad_blink
    $error("BLINK_HALF out of range");
  end

  state_t      state, state_nxt;
  logic [12:1] first_oh, first_oh_nxt;
  logic [12:1] second_oh, second_oh_nxt;
  logic [23:0] hold_cnt, hold_cnt_nxt;
  logic        err_nxt;
  logic [12:1] first_dec, second_dec;
  logic        pair_legal;

  always_comb begin
    first_dec  = '0;
    second_dec = '0;
    for (int k = 1; k <= 12; k++) begin
      if (first == 4'(k))  first_dec[k]  = 1'b1;
      if (second == 4'(k)) second_dec[k] = 1'b1;
    end
  end

  // second must be strictly below first; (0,0) is the explicit "no requests" pair.
  assign pair_legal = ((first == 4'd0) && (second == 4'd0)) ||
                      ((first >= 4'd1) && (first <= 4'd12) && (second < first));

  always_comb begin
    state_nxt     = state;
    first_oh_nxt  = first_oh;
    second_oh_nxt = second_oh;
    hold_cnt_nxt  = hold_cnt;
    err_nxt       = err;
    if (load) begin
      if (pair_legal) begin
        state_nxt     = SHOW;
        first_oh_nxt  = first_dec;
        second_oh_nxt = second_dec;
        hold_cnt_nxt  = HOLD_RELOAD;
        err_nxt       = 1'b0;
      end else begin
        state_nxt     = IDLE;
        first_oh_nxt  = '0;
        second_oh_nxt = '0;
        hold_cnt_nxt  = '0;
        err_nxt       = 1'b1;
      end
    end else if (state == SHOW) begin
      if (hold_cnt == 24'd0) begin
        state_nxt     = IDLE;
        first_oh_nxt  = '0;
        second_oh_nxt = '0;
      end else begin
        hold_cnt_nxt = hold_cnt - 24'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      first_oh  <= '0;
      second_oh <= '0;
      hold_cnt  <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      first_oh  <= first_oh_nxt;
      second_oh <= second_oh_nxt;
      hold_cnt  <= hold_cnt_nxt;
      err       <= err_nxt;
    end
  end

`ifdef DUAL_PRIORITY_BLINK_EN
  localparam logic [23:0] BLINK_LAST = 24'(BLINK_HALF - 1);

  logic        phase, phase_nxt;
  logic [23:0] blink_cnt, blink_cnt_nxt;

  // Phase restarts "on" at every legal load and is parked "on" outside SHOW.
  always_comb begin
    phase_nxt     = phase;
    blink_cnt_nxt = blink_cnt;
    if (load && pair_legal) begin
      phase_nxt     = 1'b1;
      blink_cnt_nxt = '0;
    end else if (state_nxt == SHOW) begin
      if (blink_cnt == BLINK_LAST) begin
        phase_nxt     = ~phase;
        blink_cnt_nxt = '0;
      end else begin
        blink_cnt_nxt = blink_cnt + 24'd1;
      end
    end else begin
      phase_nxt     = 1'b1;
      blink_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase     <= 1'b1;
      blink_cnt <= '0;
    end else begin
      phase     <= phase_nxt;
      blink_cnt <= blink_cnt_nxt;
    end
  end

  assign r = first_oh | (second_oh & {12{phase}});
`else
  assign r = first_oh | second_oh;
`endif

  assign valid = (state == SHOW);

endmodule

// File: tb/tb_dual_priority_decoder.sv
// tb/tb_dual_priority_decoder.sv - scoreboard bench for dual_priority_decoder against a timeline reference model
module tb_dual_priority_decoder;

  localparam int HOLD  = 8;
  localparam int BLINK = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [3:0]  first = '0;
  logic [3:0]  second = '0;
  logic [12:1] r;
  logic        valid;
  logic        err;

  typedef struct packed {
    logic [12:1] r;
    logic        valid;
    logic        err;
    logic [15:0] cyc;
  } exp_t;

  exp_t exp_q[$];

  int tests = 0;
  int fails = 0;

  // Reference model: a load time, the latched indices and elapsed cycles since the load.
  int unsigned cyc = 0;
  bit          shown = 0;
  int unsigned t0 = 0;
  int          mf = 0;
  int          ms = 0;
  bit          merr = 0;

  dual_priority_decoder #(
    .HOLD_CYCLES(HOLD),
    .BLINK_HALF (BLINK)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .first (first),
    .second(second),
    .r     (r),
    .valid (valid),
    .err   (err)
  );

  always #5 clk = ~clk;

  function automatic logic [12:1] onehot(int k);
    logic [12:1] v;
    v = '0;
    if (k >= 1 && k <= 12) v[k] = 1'b1;
    return v;
  endfunction

  function automatic bit is_legal(int f, int s);
    return (f == 0 && s == 0) || (f >= 1 && f <= 12 && s < f);
  endfunction

  task automatic step(bit ld, int f, int s);
    exp_t        e;
    int unsigned el;
    logic [12:1] sec;
    @(negedge clk);
    load   = ld;
    first  = 4'(f);
    second = 4'(s);
    if (ld) begin
      if (is_legal(f, s)) begin
        shown = 1; t0 = cyc; mf = f; ms = s; merr = 0;
      end else begin
        shown = 0; merr = 1;
      end
    end
    el = cyc - t0;
    if (shown && el >= HOLD) shown = 0;
    sec = onehot(ms);
`ifdef DUAL_PRIORITY_BLINK_EN
    if (((el / BLINK) % 2) != 0) sec = '0;
`endif
    e.r     = shown ? (onehot(mf) | sec) : 12'h000;
    e.valid = shown;
    e.err   = merr;
    e.cyc   = 16'(cyc);
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic check_zero(string name);
    tests++;
    if (r !== 12'h000 || valid !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL %s: got r=%03h valid=%0b err=%0b, need r=000 valid=0 err=0", name, r, valid, err);
    end
  endtask

  // Monitor: one expected entry per clock edge, compared just after that edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if (r !== e.r || valid !== e.valid || err !== e.err) begin
          fails++;
          $display("FAIL out@edge%0d: got r=%03h valid=%0b err=%0b, need r=%03h valid=%0b err=%0b",
                   e.cyc, r, valid, err, e.r, e.valid, e.err);
        end
      end
    end
  end

  initial begin
    int f, s;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_state");
    @(negedge clk);
    reset = 1'b0;

    idle(5);

    step(1, 12, 3); idle(9);

    step(1, 5, 5);  idle(2);
    step(1, 13, 0); idle(2);
    step(1, 0, 2);  idle(2);
    step(1, 1, 0);  idle(9);

    step(1, 7, 2);  idle(5);
    step(1, 4, 0);  idle(10);

    // Reload on the exact expiry edge.
    step(1, 3, 1);  idle(7);
    step(1, 2, 1);  idle(9);

    step(1, 0, 0);  idle(9);
    step(1, 9, 6);  idle(9);
    step(1, 12, 11); step(1, 15, 15); step(1, 6, 0); idle(9);

    // Async reset between edges while SHOW with err history.
    step(1, 8, 4); idle(3);
    @(negedge clk);
    load = 1'b0;
    #1;
    tests++;
    if (valid !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_valid: got %0b, need 1", valid);
    end
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    reset = 1'b0;
    shown = 0; merr = 0;
    idle(3);

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 9) < 7) begin
          f = $urandom_range(0, 12);
          s = (f == 0) ? 0 : $urandom_range(0, f - 1);
        end else begin
          f = $urandom_range(0, 15);
          s = $urandom_range(0, 15);
        end
        step(1, f, s);
      end else begin
        step(0, $urandom_range(0, 15), $urandom_range(0, 15));
      end
    end
    idle(2);

    @(posedge clk);
    #4;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, need 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dual_priority_decoder.md
# dual_priority_decoder

Reverse path of the dual priority encoder. It accepts a {first, second} index pair, where each index is 0 for none and 1..12 for a request line. It validates the pair, latches it, and regenerates a 12-bit line vector with at most two bits set, for driving the board LEDs or loop-back checking. The decoded pattern is held for a programmable time, then cleared. An optional blink mode distinguishes the second-priority line.

## Interface
- HOLD_CYCLES, 12_000_000: display hold time in clocks after an accepted load; legal range is 1 to 2^24-1.
- BLINK_HALF, 3_000_000: blink half-period in clocks; legal range is 1 to 2^24-1; used only when the blink feature is compiled in.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- load  in  1  single-cycle strobe; samples first/second.
- first  in  4  highest-priority index, 0..12.
- second  in  4  second-priority index, 0..12.
- r  out  12, [12:1]  decoded line vector; r[k] is set when line k is indicated.
- valid  out  1  high while a validated pattern is held.
- err  out  1  set when the most recent load was an illegal pair.

## Operation
- Two-state FSM:
  - IDLE: r=0, valid=0.
  - SHOW: r=pattern, valid=1.
- Legal pair: one of the following.
  - first=0 and second=0.
  - first in 1..12 and second=0.
  - first in 1..12 and second in 1..(first-1).
  - Anything else is illegal, including codes 13..15, second≥first with first≠0, and first=0 with second≠0.
- load with a legal pair, in either state:
  - Latch pattern = onehot(first) | onehot(second), where onehot(0)=0.
  - Enter SHOW, hold counter = HOLD_CYCLES-1, err=0.
  - Reload while in SHOW restarts the hold.
- load with an illegal pair, in either state:
  - Go to IDLE, r=0, valid=0, err=1.
  - err stays set until the next legal load or reset.
- SHOW: the hold counter decrements every cycle without load. When it is 0 and no load is present, go to IDLE, r=0, valid=0, err unchanged.
- A legal (0,0) load enters SHOW with r=0 and valid=1. This is an explicit "no requests" display.
- Hold counter width is 24 bits; arithmetic is unsigned, no wrap. The counter is not decremented below 0.

## Timing
- Reset (async assert, sampled on release): state=IDLE, r=0, valid=0, err=0, hold counter=0, blink phase=on, blink counter=0.
- Latency: load sampled on edge N → r, valid and err updated on edge N, visible in cycle N+1. All outputs are registered; there is no combinational path from inputs to outputs.
- The hold lasts exactly HOLD_CYCLES cycles of valid=1 after the load edge, absent reloads.
- Load in the same cycle as hold expiry: load wins, and the pattern and hold are refreshed.
- Reset asserted mid-SHOW: outputs clear immediately, asynchronously.
- No back-pressure: load is accepted every cycle and back-to-back loads are legal. The last load in a run determines the state.

## Configuration
- DUAL_PRIORITY_BLINK_EN defined:
  - The second-line bit of r is ANDed with a blink phase. The phase toggles every BLINK_HALF cycles while in SHOW.
  - Phase and blink counter reset to "on" and 0 at each accepted legal load.
  - The first-line bit stays steady.
  - In IDLE the blink counter is held at 0.
- Undefined: no blink logic is synthesized, BLINK_HALF is ignored, and r shows both bits steady for the whole hold.

## Test plan
Parameters for all scenarios: HOLD_CYCLES=8, BLINK_HALF=2.

- Reset then idle 5 cycles → r=0, valid=0, err=0 throughout.
- load (first=12, second=3) at cycle 0 → cycles 1..8 r=12'b1000_0000_0100 (r[12], r[3] set), valid=1. Cycle 9 → r=0, valid=0, err=0.
- load (5,5), then load (13,0), then load (0,2), each separated by 2 cycles → after each: err=1, r=0, valid=0. A following load (1,0) → r[1]=1 only, err=0.
- load (7,2) at cycle 0, reload (4,0) at cycle 6, the cycle-7 edge → pattern becomes r[4] only. valid stays 1 through cycle 14, drops in cycle 15. Separately, a reload landing exactly on the hold-expiry cycle must also extend the hold.
- Assert reset asynchronously mid-SHOW, between clock edges → r, valid and err go to 0 before the next edge. After release, IDLE.
- With DUAL_PRIORITY_BLINK_EN, load (9,6) → r[9] steady for 8 cycles. r[6] follows the pattern 1,1,0,0,1,1,0,0 over cycles 1..8. Without the macro, r[6]=1 for all 8 cycles.
